// File: rtl/sat_accum_unit.sv
// sat_accum_unit
// Streaming saturating accumulator. A burst of WIDTH-bit operands is summed
// into one result. Each burst uses either signed or unsigned-with-signed-offset
// arithmetic, and either clamps or wraps on overflow. The unit tracks sticky
// positive/negative overflow flags and a saturating beat count.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous abort; drops partial burst and held result
//   in_valid/ready  operand handshake (beat = in_valid && in_ready)
//   in_data         operand, two's complement
//   in_last         final beat of the burst
//   in_signed       1 = signed accumulator (sampled on first beat)
//   in_sat          1 = clamp on overflow, 0 = wrap (sampled on first beat)
//   out_valid/ready result handshake
//   out_result      accumulated value
//   out_po, out_no  sticky positive / negative overflow for the burst
//   out_count       beats in the burst, saturating at all-ones
module sat_accum_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_signed,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_po,
    output logic             out_no,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic             po;
        logic             no;
        logic [WIDTH-1:0] val;
    } step_t;

    localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] U_MAX   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] U_MIN   = {WIDTH{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // One accumulation step: modular sum, overflow detection, optional clamp.
    // In unsigned mode the operand is a signed offset, so overflow is judged
    // by whether the unsigned sum moved in the direction the offset's sign says.
    function automatic step_t acc_step(input logic [WIDTH-1:0] acc,
                                       input logic [WIDTH-1:0] d,
                                       input logic             sgn,
                                       input logic             sat);
        step_t            r;
        logic [WIDTH-1:0] s;
        logic             lt;
        s  = acc + d;
        lt = (s < acc);
        if (sgn) begin
            r.po = !acc[WIDTH-1] && !d[WIDTH-1] &&  s[WIDTH-1];
            r.no =  acc[WIDTH-1] &&  d[WIDTH-1] && !s[WIDTH-1];
        end else begin
            r.po = !d[WIDTH-1] &&  lt;
            r.no =  d[WIDTH-1] && !lt;
        end
        if (sat && r.po) begin
            r.val = sgn ? S_MAX : U_MAX;
        end else if (sat && r.no) begin
            r.val = sgn ? S_MIN : U_MIN;
        end else begin
            r.val = s;
        end
        return r;
    endfunction

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic             po_r;
    logic             no_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sgn_r;
    logic             sat_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_result_r;
    logic             out_po_r;
    logic             out_no_r;
    logic [CNT_W-1:0] out_count_r;

    logic             beat_s;
    step_t            step_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic             po_nxt_s;
    logic             no_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_result = out_result_r;
    assign out_po     = out_po_r;
    assign out_no     = out_no_r;
    assign out_count  = out_count_r;

    // Next accumulator, flag and count values for a beat accepted this cycle.
    // The first beat of a burst loads the operand directly and clears history.
    always_comb begin
        beat_s    = in_valid && in_ready_r && !flush;
        step_s    = acc_step(acc_r, in_data, sgn_r, sat_r);
        acc_nxt_s = step_s.val;
        po_nxt_s  = po_r | step_s.po;
        no_nxt_s  = no_r | step_s.no;
        cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
        if (state_r == ST_IDLE) begin
            acc_nxt_s = in_data;
            po_nxt_s  = 1'b0;
            no_nxt_s  = 1'b0;
            cnt_nxt_s = CNT_ONE;
        end else begin
            acc_nxt_s = step_s.val;
        end
    end

    // Burst control FSM with accumulator state and registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            acc_r        <= {WIDTH{1'b0}};
            po_r         <= 1'b0;
            no_r         <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            sgn_r        <= 1'b0;
            sat_r        <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_po_r     <= 1'b0;
            out_no_r     <= 1'b0;
            out_count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_ACCUM: begin
                    if (beat_s) begin
                        acc_r <= acc_nxt_s;
                        po_r  <= po_nxt_s;
                        no_r  <= no_nxt_s;
                        cnt_r <= cnt_nxt_s;
                        if (state_r == ST_IDLE) begin
                            sgn_r <= in_signed;
                            sat_r <= in_sat;
                        end else begin
                            sgn_r <= sgn_r;
                            sat_r <= sat_r;
                        end
                        if (in_last) begin
                            state_r      <= ST_HOLD;
                            in_ready_r   <= 1'b0;
                            out_valid_r  <= 1'b1;
                            out_result_r <= acc_nxt_s;
                            out_po_r     <= po_nxt_s;
                            out_no_r     <= no_nxt_s;
                            out_count_r  <= cnt_nxt_s;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sat_accum_unit.sv
module tb_sat_accum_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_signed;
    logic       in_sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic       out_po;
    logic       out_no;
    logic [7:0] out_count;

    // second instance with a 2-bit counter for count saturation
    logic       c_in_ready;
    logic       c_out_valid;
    logic [7:0] c_out_result;
    logic       c_out_po;
    logic       c_out_no;
    logic [1:0] c_out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sat_accum_unit #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_signed(in_signed), .in_sat(in_sat),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_po(out_po), .out_no(out_no), .out_count(out_count)
    );

    sat_accum_unit #(.WIDTH(8), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .in_last(in_last), .in_signed(in_signed), .in_sat(in_sat),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_result(c_out_result),
        .out_po(c_out_po), .out_no(c_out_no), .out_count(c_out_count)
    );

    // drive one beat at the falling edge, return #1 after the capturing edge
    task automatic send(input logic [7:0] d, input logic last,
                        input logic sgn, input logic sat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        in_signed = sgn;
        in_sat    = sat;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'hXX;
    endtask

    // accept the held result with out_ready for one cycle
    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_last = 1'b0; in_signed = 1'b0; in_sat = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if ({out_result, out_po, out_no, out_count} !== 18'd0) begin errors++; $display("FAIL reset_outs got %h want 0", {out_result, out_po, out_no, out_count}); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_signed_sat();
        send(8'd100, 1'b0, 1'b1, 1'b1);
        send(8'd50,  1'b0, 1'b0, 1'b0);  // mode ignored on non-first beat
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ss_early_valid got %b want 0", out_valid); end
        send(8'hF6,  1'b1, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ss_latency got %b want 1", out_valid); end
        checks++; if (out_result !== 8'd117) begin errors++; $display("FAIL ss_result got %0d want 117", out_result); end
        checks++; if ({out_po, out_no} !== 2'b10) begin errors++; $display("FAIL ss_flags got %b want 10", {out_po, out_no}); end
        checks++; if (out_count !== 8'd3) begin errors++; $display("FAIL ss_count got %0d want 3", out_count); end
        consume();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL ss_release got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_unsigned_sat();
        send(8'd10, 1'b0, 1'b0, 1'b1);
        send(8'hEC, 1'b1, 1'b1, 1'b0);
        checks++; if (out_result !== 8'd0) begin errors++; $display("FAIL us_low_result got %0d want 0", out_result); end
        checks++; if ({out_po, out_no} !== 2'b01) begin errors++; $display("FAIL us_low_flags got %b want 01", {out_po, out_no}); end
        consume();
        send(8'd250, 1'b0, 1'b0, 1'b1);
        send(8'd10,  1'b1, 1'b1, 1'b0);
        checks++; if (out_result !== 8'd255) begin errors++; $display("FAIL us_high_result got %0d want 255", out_result); end
        checks++; if ({out_po, out_no} !== 2'b10) begin errors++; $display("FAIL us_high_flags got %b want 10", {out_po, out_no}); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL us_high_count got %0d want 2", out_count); end
        consume();
    endtask

    task automatic test_wrap();
        send(8'd200, 1'b0, 1'b0, 1'b0);
        send(8'd100, 1'b1, 1'b1, 1'b1);
        checks++; if (out_result !== 8'd44) begin errors++; $display("FAIL uw_result got %0d want 44", out_result); end
        checks++; if ({out_po, out_no} !== 2'b10) begin errors++; $display("FAIL uw_flags got %b want 10", {out_po, out_no}); end
        consume();
        send(8'h80, 1'b0, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0, 1'b1);
        checks++; if (out_result !== 8'd127) begin errors++; $display("FAIL sw_result got %0d want 127", out_result); end
        checks++; if ({out_po, out_no} !== 2'b01) begin errors++; $display("FAIL sw_flags got %b want 01", {out_po, out_no}); end
        consume();
    endtask

    task automatic test_backpressure();
        send(8'h55, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if ({in_ready, out_valid} !== 2'b01) begin errors++; $display("FAIL bp_hs[%0d] got %b want 01", i, {in_ready, out_valid}); end
            checks++; if ({out_result, out_count} !== {8'h55, 8'd1}) begin errors++; $display("FAIL bp_hold[%0d] got %h want 5501", i, {out_result, out_count}); end
        end
        consume();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b want 01", {out_valid, in_ready}); end
    endtask

    task automatic test_async_reset();
        send(8'd1, 1'b0, 1'b1, 1'b1);
        send(8'd2, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", out_valid); end
        checks++; if ({out_result, out_po, out_no, out_count} !== 18'd0) begin errors++; $display("FAIL ar_outs got %h want 0", {out_result, out_po, out_no, out_count}); end
        #4;
        rst = 1'b0;
        send(8'd3, 1'b0, 1'b0, 1'b1);
        send(8'd4, 1'b1, 1'b0, 1'b0);
        checks++; if ({out_valid, out_result} !== {1'b1, 8'd7}) begin errors++; $display("FAIL ar_result got %h want 107", {out_valid, out_result}); end
        checks++; if (out_count !== 8'd2) begin errors++; $display("FAIL ar_count got %0d want 2", out_count); end
        consume();
    endtask

    task automatic test_flush();
        send(8'd9, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        out_ready = 1'b0;
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL fl_hold got %b want 01", {out_valid, in_ready}); end
        // partial burst then flush with a last beat on the same cycle
        send(8'd20, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1; in_data = 8'd30; in_last = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fl_drop_valid got %b want 0", out_valid); end
        send(8'd5, 1'b1, 1'b1, 1'b1);
        checks++; if ({out_result, out_count} !== {8'd5, 8'd1}) begin errors++; $display("FAIL fl_fresh got %h want 0501", {out_result, out_count}); end
        consume();
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 5; i++) send(8'd1, (i == 4), 1'b0, 1'b1);
        checks++; if (c_out_count !== 2'd3) begin errors++; $display("FAIL cs_count2 got %0d want 3", c_out_count); end
        checks++; if ({c_out_valid, c_out_result} !== {1'b1, 8'd5}) begin errors++; $display("FAIL cs_result2 got %h want 105", {c_out_valid, c_out_result}); end
        checks++; if (out_count !== 8'd5) begin errors++; $display("FAIL cs_count8 got %0d want 5", out_count); end
        consume();
    endtask

    initial begin
        test_reset();
        test_signed_sat();
        test_unsigned_sat();
        test_wrap();
        test_backpressure();
        test_async_reset();
        test_flush();
        test_count_sat();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_accum_unit.md
Name: sat_accum_unit

Overview:
- Streaming saturating accumulator.
- Sums a burst of WIDTH-bit operands into one result, with per-burst signed or unsigned-with-signed-offset clamping.
- Sticky positive-overflow and negative-overflow flags, plus a beat count.
- Sits beside the ALU as a multi-cycle reduction helper, for example packed-SIMD sum-of-elements and saturating-add instruction sequences; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand and accumulator width in bits (>=2).
- CNT_W, 8, width of the beat counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous abort; drops any partial or pending result.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  unit accepts a beat this cycle.
- in_data  input  WIDTH  operand (two's complement in both modes).
- in_last  input  1  final beat of the burst.
- in_signed  input  1  1 = signed accumulator, 0 = unsigned accumulator; sampled on the first beat only.
- in_sat  input  1  1 = clamp on overflow, 0 = wrap; sampled on the first beat only.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  accumulated value.
- out_po  output  1  sticky positive overflow seen during the burst.
- out_no  output  1  sticky negative overflow seen during the burst.
- out_count  output  CNT_W  beats accepted in the burst; saturates at all-ones.

Behaviour:
- Beat = in_valid && in_ready. States are IDLE, ACCUM and HOLD.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - acc, flags, count, out_result, out_po, out_no and out_count go to 0.
  - out_valid goes to 0; in_ready = 1 after reset deasserts.
- IDLE: in_ready=1.
  - On a beat, latch mode (in_signed, in_sat) and compute with acc treated as 0, so acc = in_data. With acc=0 no overflow is possible.
  - Count goes to 1.
  - Next state is HOLD if in_last, else ACCUM.
- ACCUM: in_ready=1.
  - Each beat computes acc = f(acc, in_data) using the latched mode and increments count (saturating).
  - in_last moves the state to HOLD; otherwise stay in ACCUM.
- HOLD: in_ready=0, out_valid=1.
  - out_result, out_po, out_no and out_count are registered and stable while out_valid && !out_ready.
  - When out_ready, go to IDLE; in_ready is 1 in the next cycle.
  - There is no same-cycle accept of a new beat in HOLD.
- Latency: the last beat at cycle n gives out_valid=1 at cycle n+1. Throughput is one beat per cycle within a burst, plus at least one HOLD cycle per burst.
- Signed mode:
  - s = acc + in_data, computed modulo 2^WIDTH.
  - PO = !acc[MSB] && !d[MSB] && s[MSB].
  - NO = acc[MSB] && d[MSB] && !s[MSB].
  - If sat: PO clamps to {0,1..1} and NO clamps to {1,0..0}.
- Unsigned mode:
  - acc is unsigned; in_data is a signed offset.
  - s = acc + in_data, modulo 2^WIDTH.
  - PO = !d[MSB] && (s <u acc).
  - NO = d[MSB] && !(s <u acc).
  - If sat: PO clamps to all-ones and NO clamps to 0.
- Wrap mode (in_sat=0): acc = s, but PO/NO are still computed and recorded.
- Flags are sticky for the burst: each beat ORs the per-beat PO into the flag and the per-beat NO into the flag. Both flags may end up set.
- The clamped value is carried forward: later beats add to the clamped acc. For example, signed 8-bit: 127 (clamped) + (-10) = 117.
- Flags and count clear on the first beat of a new burst.
- flush:
  - Next state is IDLE from any state; out_valid goes to 0 next cycle.
  - The partial burst and any held result are discarded. A beat presented in the same cycle as flush is dropped.
  - flush outranks in_last and out_ready.
- mode inputs are don't-care on non-first beats. in_data, in_last and mode inputs are don't-care when in_valid=0.

Test Plan:
- WIDTH=8, signed, sat: beats 100, 50, -10(last) -> out_result=117, out_po=1, out_no=0, out_count=3, out_valid exactly 1 cycle after the last beat.
- WIDTH=8, unsigned, sat: beats 10, 0xEC(-20, last) -> out_result=0, out_no=1, out_po=0. Then a new burst 250, 10(last) -> out_result=255, out_po=1, out_no=0 (flags cleared).
- WIDTH=8, unsigned, wrap (in_sat=0): 200, 100(last) -> out_result=44, out_po=1. Signed wrap: -128, -1(last) -> 127, out_no=1.
- Backpressure: a single-beat burst 0x55 with in_last, then out_ready=0 for 3 cycles -> in_ready=0 and outputs stable at 0x55/count=1 throughout. out_ready=1 -> IDLE next cycle, with in_ready=1.
- Reset asserted mid-ACCUM (after 2 beats), asynchronously between edges -> outputs go to 0 immediately. After release, a fresh burst 3, 4(last) -> 7, count=2.
- flush during HOLD with out_ready=1 in the same cycle -> result dropped, out_valid=0 next cycle. CNT_W=2 with a 5-beat burst -> out_count=3 (saturated).
